m_dram_store_buffer: RTL
========================

Name: m_dram_store_buffer

Overview:
- Write-side initiator for the multi-cycle DRAM request/ack protocol. The instruction path uses that protocol to read (request pulse in, one-cycle output-enable pulse back after D_DELAY cycles); this block is the store path into the same DRAM.
- Accepts stores from the pipeline MA stage into a small FIFO and drains them, one at a time and oldest first, as single-cycle write requests. Each request is held stable until the DRAM returns a one-cycle ack.
- Sits between the processor data-memory port and the DRAM write port. Stalls the pipeline only when the FIFO is full.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
TIMEOUT, 15, cycles to wait for ack before reissuing; 1..255.

Ports:
w_clock  in  1  clock; all state updates on posedge.
w_rst_n  in  1  reset; synchronous, active-low.
w_push  in  1  store request from MA stage.
w_paddr  in  32  store byte address; bits [1:0] ignored.
w_pdata  in  32  store data.
w_full  out  1  FIFO full; pipeline must stall the store.
w_empty  out  1  FIFO empty and FSM in IDLE (buffer drained).
r_dreq  out  1  write request pulse to DRAM.
r_daddr  out  32  write address, word aligned.
r_ddata  out  32  write data.
w_dack  in  1  one-cycle write-complete pulse from DRAM.
r_err  out  1  sticky: at least one timeout occurred.
w_laddr  in  32  load address for forwarding (STORE_FWD_EN only).
w_fwd_hit  out  1  load hits a buffered store (STORE_FWD_EN only).
w_fwd_data  out  32  newest matching store data (STORE_FWD_EN only).

Behaviour:
- Reset (w_rst_n=0 at a posedge) has priority over all other inputs:
  - FIFO pointers and count cleared; FSM to IDLE; timeout counter cleared.
  - Outputs: r_dreq=0, r_daddr=0, r_ddata=0, r_err=0, w_full=0, w_empty=1.
  - A reset mid-transaction drops the outstanding write. Any w_dack arriving afterwards is ignored.
- FIFO:
  - Push accepted at a posedge when w_push & !w_full. Entry stored as {w_paddr[31:2],2'b00, w_pdata}.
  - w_full = (count==DEPTH). When full, a push is refused even if a pop occurs in the same cycle; there is no push-through.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if count!=0, latch the head entry into r_daddr/r_ddata and go to ISSUE.
  - ISSUE: r_dreq=1 for exactly this one cycle; clear the timeout counter; go to WAIT.
  - WAIT: r_dreq=0, r_daddr/r_ddata held.
    - On w_dack: pop head, go to IDLE.
    - Else increment the counter. When it reaches TIMEOUT, set r_err and go to ISSUE to reissue the same head entry.
  - r_dreq is registered and equals (state==ISSUE).
  - w_dack is ignored in IDLE and ISSUE.
- Latency (FSM idle, FIFO empty):
  - Push accepted at edge N → r_dreq high during cycle N+1..N+2.
  - Ack at edge M → entry popped at M. The next request is high no earlier than M+1..M+2 (one IDLE bubble, matching the DRAM return-to-idle).
- w_empty = (count==0) & (state==IDLE).
- Ordering: strictly FIFO; the head is never popped without an ack.

Optional Feature:
STORE_FWD_EN
- Defined: combinational compare of w_laddr[31:2] against every valid entry, including the in-flight head.
  - w_fwd_hit=1 on any match.
  - w_fwd_data = data of the youngest matching entry.
- Not defined: no compare logic; w_fwd_hit tied 0, w_fwd_data tied 0; w_laddr unused.

Test Plan:
- Reset then idle → r_dreq=0, w_empty=1, w_full=0, r_err=0 for 10 cycles.
- Push addr 0x104, data 0xDEADBEEF at edge 5; bench acks 3 cycles after the request → r_dreq one cycle, r_daddr=0x104, r_ddata=0xDEADBEEF; w_empty=1 after the ack edge.
- Push 5 stores with DEPTH=4 and acks withheld → w_full=1 after the 4th; 5th refused. Then issue acks → DRAM sees addresses 0x0,0x4,0x8,0xC in order; each new request follows its ack by 2 cycles.
- Ack edge with simultaneous push while full → push refused, count drops to 3. Ack with simultaneous push at count 1 → count stays 1, new entry issued next.
- No ack for TIMEOUT=15 cycles → r_err=1, same address reissued; a later ack pops it; r_err stays 1 until reset. Reset asserted during WAIT → all reset values; a stale ack is ignored.
- STORE_FWD_EN: push 0x20=7 then 0x20=9, w_laddr=0x22 → w_fwd_hit=1, w_fwd_data=9. w_laddr=0x40 → hit=0. Without the macro → hit=0 always.

Source files
------------

// File: rtl/m_dram_store_buffer.sv
// m_dram_store_buffer: store path into the shared DRAM.
// The block buffers stores from the MA stage in a small FIFO. It then drains the FIFO oldest
// first as single-cycle write requests. Each request waits for a one-cycle ack and is
// reissued if the ack never comes.
// Optional build macro STORE_FWD_EN adds a load-address compare against all buffered stores.
module m_dram_store_buffer #(
  parameter int DEPTH   = 4,   // FIFO entries, power of two 2..16
  parameter int TIMEOUT = 15   // wait cycles before a reissue, 1..255
) (
  input  logic        w_clock,
  input  logic        w_rst_n,
  input  logic        w_push,
  input  logic [31:0] w_paddr,
  input  logic [31:0] w_pdata,
  output logic        w_full,
  output logic        w_empty,
  output logic        r_dreq,
  output logic [31:0] r_daddr,
  output logic [31:0] r_ddata,
  input  logic        w_dack,
  output logic        r_err,
  input  logic [31:0] w_laddr,
  output logic        w_fwd_hit,
  output logic [31:0] w_fwd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  logic [29:0]   mem_addr [DEPTH];   // word address; byte offset is always zero
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    tmo_cnt;
  state_t        state, state_next;
  logic          push_ok, pop;

  assign w_full  = (count == CW'(DEPTH));
  assign w_empty = (count == '0) && (state == S_IDLE);
  // No push-through: a full FIFO refuses even when the head pops this cycle.
  assign push_ok = w_push & ~w_full;
  assign pop     = (state == S_WAIT) & w_dack;

  // Entry storage, written at the tail.
  // NOTE: storage is deliberately not reset; count alone says which entries are valid.
  always_ff @(posedge w_clock) begin
    if (push_ok) begin
      mem_addr[wr_ptr] <= w_paddr[31:2];
      mem_data[wr_ptr] <= w_pdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge w_clock) begin
    if (!w_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments to avoid ordering races.
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Next-state decode for the drain FSM.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      S_IDLE:  if (count != '0) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (w_dack)                    state_next = S_IDLE;
        else if (tmo_cnt == TMO_LAST)  state_next = S_ISSUE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register plus the registered DRAM-side outputs and timeout tracking.
  always_ff @(posedge w_clock) begin
    if (!w_rst_n) begin
      state   <= S_IDLE;
      r_dreq  <= 1'b0;
      r_daddr <= '0;
      r_ddata <= '0;
      r_err   <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state  <= state_next;
      r_dreq <= (state_next == S_ISSUE);
      if (state == S_IDLE && count != '0) begin
        r_daddr <= {mem_addr[rd_ptr], 2'b00};
        r_ddata <= mem_data[rd_ptr];
      end
      if (state == S_ISSUE) begin
        tmo_cnt <= '0;
      end else if (state == S_WAIT && !w_dack) begin
        tmo_cnt <= tmo_cnt + 8'd1;
        if (tmo_cnt == TMO_LAST) r_err <= 1'b1;
      end
    end
  end

`ifdef STORE_FWD_EN
  logic [AW-1:0] idx;
  logic          unused_bits;
  assign unused_bits = ^w_paddr[1:0];

  // Scan valid entries oldest to youngest so the youngest match wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (CW'(i) < count && mem_addr[idx] == w_laddr[31:2]) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = mem_data[idx];
      end
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{w_laddr, w_paddr[1:0]};
  assign w_fwd_hit   = 1'b0;
  assign w_fwd_data  = '0;
`endif

endmodule
